// File: rtl/riscv_pipe_stage_reg_pkg.sv
// Shared types and helpers for the inter-stage pipeline register.
package riscv_pipe_stage_reg_pkg;

   localparam int CNT_W = 2;

   typedef logic [CNT_W-1:0] cnt_t;

   // Number of held entries, given the main and skid valid flags.
   function automatic cnt_t occupancy(input logic main_vld, input logic skid_vld);
      return cnt_t'({1'b0, main_vld}) + cnt_t'({1'b0, skid_vld});
   endfunction

endpackage

// File: rtl/riscv_configs.v
// Shared RV32I core configuration: register width and channel-packing helpers.
`ifndef RISCV_CONFIGS_V
`define RISCV_CONFIGS_V

`define XLEN 32

// Word k of a bus that packs words of `XLEN bits, word 0 in the LSBs.
`define RISCV_CH_WORD(bus, k) bus[(k)*`XLEN +: `XLEN]

// Total width of a bus carrying n packed `XLEN words.
`define RISCV_CH_BUS_W(n) ((n)*`XLEN)

`endif

// File: rtl/riscv_pipe_data_slot.sv
// Load-enabled NUM_CH*`XLEN data register; synchronous active-low reset
// loads REGISTER_INIT into every word.
`include "riscv_configs.v"

module riscv_pipe_data_slot
   import riscv_pipe_stage_reg_pkg::*;
#(
   parameter int               NUM_CH        = 6,
   parameter logic [`XLEN-1:0] REGISTER_INIT = '0
) (
   input  logic                               i_clk,
   input  logic                               i_rstn,
   input  logic                               i_load,
   input  logic [`RISCV_CH_BUS_W(NUM_CH)-1:0] i_d,
   output logic [`RISCV_CH_BUS_W(NUM_CH)-1:0] o_q
);

   // Payload only changes on reset or an explicit load.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         o_q <= {NUM_CH{REGISTER_INIT}};
      end else if (i_load) begin
         o_q <= i_d;
      end
   end

endmodule

// File: rtl/riscv_pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, stall, flush and
// occupancy count. Define RISCV_PIPE_SKID_EN to add a skid entry so o_ready
// comes from a flop instead of a combinational path from i_ready.
`include "riscv_configs.v"

module riscv_pipe_stage_reg
   import riscv_pipe_stage_reg_pkg::*;
#(
   parameter int               NUM_CH        = 6,
   parameter logic [`XLEN-1:0] REGISTER_INIT = '0
) (
   input  logic                               i_clk,
   input  logic                               i_rstn,
   input  logic [`RISCV_CH_BUS_W(NUM_CH)-1:0] i_data,
   input  logic                               i_valid,
   output logic                               o_ready,
   output logic [`RISCV_CH_BUS_W(NUM_CH)-1:0] o_data,
   output logic                               o_valid,
   input  logic                               i_ready,
   input  logic                               i_flush,
   output logic [1:0]                         o_count
);

   localparam int DW = `RISCV_CH_BUS_W(NUM_CH);

   logic          vld_p0;
   logic          vld_nxt;
   logic          main_ld;
   logic [DW-1:0] main_d;
   logic          fire_in;
   logic          fire_out;
   cnt_t          cnt_q;

   assign fire_in  = i_valid & o_ready;
   assign fire_out = vld_p0 & i_ready;
   assign o_valid  = vld_p0;
   assign o_count  = cnt_q;

`ifdef RISCV_PIPE_SKID_EN
   logic          skid_vld_p0;
   logic          skid_nxt;
   logic          skid_ld;
   logic [DW-1:0] skid_q;
   logic          rdy_q;

   assign o_ready = rdy_q;

   // Next-state: drain skid into main, refill main, or park a stalled beat in skid.
   always_comb begin
      vld_nxt  = vld_p0;
      skid_nxt = skid_vld_p0;
      main_ld  = 1'b0;
      skid_ld  = 1'b0;
      main_d   = i_data;
      if (fire_out) begin
         if (skid_vld_p0) begin
            main_ld  = 1'b1;
            main_d   = skid_q;
            skid_nxt = 1'b0;
         end else if (fire_in) begin
            main_ld  = 1'b1;
         end else begin
            vld_nxt  = 1'b0;
         end
      end else if (fire_in) begin
         if (vld_p0) begin
            skid_ld  = 1'b1;
            skid_nxt = 1'b1;
         end else begin
            main_ld  = 1'b1;
            vld_nxt  = 1'b1;
         end
      end
   end

   // Control flops; flush wins over every move, reset wins over flush.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         vld_p0      <= 1'b0;
         skid_vld_p0 <= 1'b0;
         rdy_q       <= 1'b1;
         cnt_q       <= '0;
      end else if (i_flush) begin
         vld_p0      <= 1'b0;
         skid_vld_p0 <= 1'b0;
         rdy_q       <= 1'b1;
         cnt_q       <= '0;
      end else begin
         vld_p0      <= vld_nxt;
         skid_vld_p0 <= skid_nxt;
         rdy_q       <= ~skid_nxt;
         cnt_q       <= occupancy(vld_nxt, skid_nxt);
      end
   end

   riscv_pipe_data_slot #(
      .NUM_CH        (NUM_CH),
      .REGISTER_INIT (REGISTER_INIT)
   ) u_skid_slot (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .i_load (skid_ld & ~i_flush),
      .i_d    (i_data),
      .o_q    (skid_q)
   );
`else
   assign o_ready = ~vld_p0 | i_ready;

   // Next-state: a new beat always lands in main; a bare drain empties it.
   always_comb begin
      vld_nxt = vld_p0;
      main_ld = 1'b0;
      main_d  = i_data;
      if (fire_in) begin
         main_ld = 1'b1;
         vld_nxt = 1'b1;
      end else if (fire_out) begin
         vld_nxt = 1'b0;
      end
   end

   // Control flops; flush wins over every move, reset wins over flush.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         vld_p0 <= 1'b0;
         cnt_q  <= '0;
      end else if (i_flush) begin
         vld_p0 <= 1'b0;
         cnt_q  <= '0;
      end else begin
         vld_p0 <= vld_nxt;
         cnt_q  <= occupancy(vld_nxt, 1'b0);
      end
   end
`endif

   riscv_pipe_data_slot #(
      .NUM_CH        (NUM_CH),
      .REGISTER_INIT (REGISTER_INIT)
   ) u_main_slot (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .i_load (main_ld & ~i_flush),
      .i_d    (main_d),
      .o_q    (o_data)
   );

endmodule

// File: tb/tb_riscv_pipe_stage_reg.sv
// Self-checking bench for riscv_pipe_stage_reg: directed scenarios followed by
// random traffic, compared against a queue-based model of the stage.
`timescale 1ns/1ps

module tb_riscv_pipe_stage_reg;

`ifdef XLEN
   localparam int XL = `XLEN;
`else
   localparam int XL = 32;
`endif
   localparam int          NUM_CH        = 3;
   localparam int          DW            = NUM_CH * XL;
   localparam logic [XL-1:0] REGISTER_INIT = 32'hA5A5_0F0F;
`ifdef RISCV_PIPE_SKID_EN
   localparam int          CAP           = 2;
`else
   localparam int          CAP           = 1;
`endif

   logic          clk = 1'b0;
   logic          i_rstn = 1'b0;
   logic [DW-1:0] i_data = '0;
   logic          i_valid = 1'b0;
   logic          o_ready;
   logic [DW-1:0] o_data;
   logic          o_valid;
   logic          i_ready = 1'b0;
   logic          i_flush = 1'b0;
   logic [1:0]    o_count;

   riscv_pipe_stage_reg #(
      .NUM_CH        (NUM_CH),
      .REGISTER_INIT (REGISTER_INIT)
   ) dut (
      .i_clk   (clk),
      .i_rstn  (i_rstn),
      .i_data  (i_data),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .o_data  (o_data),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .i_flush (i_flush),
      .o_count (o_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: the held entries in delivery order, plus the payload
   // most recently presented on o_data.
   logic [DW-1:0] mq[$];
   logic [DW-1:0] shown;
   bit            chk_en = 1'b0;

   task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic bit model_ready(input bit rdy);
      if (CAP == 2) return mq.size() < 2;
      return (mq.size() == 0) || rdy;
   endfunction

   // One clock cycle: drive inputs, check outputs produced by the previous
   // edge, then advance the model across the coming edge.
   task automatic cycle(input bit rstn, input bit v, input logic [DW-1:0] d,
                        input bit rdy, input bit fl);
      bit fo, fi, mr;
      @(negedge clk);
      i_rstn  = rstn;
      i_valid = v;
      i_data  = d;
      i_ready = rdy;
      i_flush = fl;
      #1;
      mr = model_ready(rdy);
      if (chk_en) begin
         check("o_valid", DW'(o_valid), DW'(mq.size() != 0));
         check("o_count", DW'(o_count), DW'(mq.size()));
         check("o_ready", DW'(o_ready), DW'(mr));
         check("o_data",  o_data, shown);
      end
      @(posedge clk);
      if (!rstn) begin
         mq.delete();
         shown = {NUM_CH{REGISTER_INIT}};
      end else begin
         fo = (mq.size() != 0) && rdy;
         fi = v && mr;
         if (fl) begin
            mq.delete();
         end else begin
            if (fo) void'(mq.pop_front());
            if (fi) mq.push_back(d);
         end
         if (mq.size() != 0) shown = mq[0];
      end
   endtask

   function automatic logic [DW-1:0] mk(input logic [XL-1:0] w0);
      logic [DW-1:0] r;
      for (int k = 0; k < NUM_CH; k++) r[k*XL +: XL] = XL'($urandom);
      r[XL-1:0] = w0;
      return r;
   endfunction

   initial begin
      logic [DW-1:0] dead;
      dead  = {NUM_CH{32'hDEADBEEF}};
      shown = {NUM_CH{REGISTER_INIT}};

      // Reset held two edges with traffic present.
      cycle(0, 1, dead, 1, 0);
      chk_en = 1'b1;
      cycle(0, 1, dead, 1, 0);
      check("rst_word0", DW'(o_data[XL-1:0]), DW'(REGISTER_INIT));

      // Streaming 1,2,3,4 at full rate.
      for (int i = 1; i <= 4; i++) cycle(1, 1, mk(XL'(i)), 1, 0);
      cycle(1, 0, mk(0), 1, 0);
      cycle(1, 0, mk(0), 1, 0);

      // Stall with 0x10 held and 0x20 offered.
      cycle(1, 1, mk(32'h10), 1, 0);
      for (int i = 0; i < 3; i++) cycle(1, 1, mk(32'h20), 0, 0);
      cycle(1, 1, mk(32'h20), 1, 0);
      for (int i = 0; i < 3; i++) cycle(1, 0, mk(0), 1, 0);

      // Flush with a full stage and a beat offered at the same edge.
      cycle(1, 1, mk(32'h50), 0, 0);
      cycle(1, 1, mk(32'h51), 0, 0);
      cycle(1, 1, mk(32'h30), 0, 1);
      cycle(1, 0, mk(0), 1, 0);
      cycle(1, 0, mk(0), 1, 0);

      // Simultaneous accept and drain with one entry held.
      cycle(1, 1, mk(32'h3F), 0, 0);
      cycle(1, 1, mk(32'h40), 1, 0);
      cycle(1, 0, mk(0), 0, 0);
      cycle(1, 0, mk(0), 1, 0);

      // Reset while stalled and full.
      cycle(1, 1, mk(32'h70), 0, 0);
      cycle(1, 1, mk(32'h71), 0, 0);
      cycle(0, 1, mk(32'h72), 0, 0);
      cycle(1, 0, mk(0), 1, 0);
      cycle(1, 0, mk(0), 1, 0);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(0, 49) != 0),
               ($urandom_range(0, 1) == 1),
               mk(XL'($urandom)),
               ($urandom_range(0, 2) != 0),
               ($urandom_range(0, 11) == 0));
      end
      cycle(1, 0, mk(0), 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
